// File: rtl/core_run_ctrl.sv
// Core run controller: holds core reset RESET_CYCLES after start, runs, counts, stops on ecall/self-loop/timeout.
// All outputs registered; halt detected in the RUN cycle is visible as done one edge later; no backpressure.
module core_run_ctrl #(
  parameter int unsigned RESET_CYCLES = 2,
  parameter int unsigned PC_WIDTH     = 64,
  parameter int unsigned CNT_WIDTH    = 32,
  parameter int unsigned HALT_REPEAT  = 4,
  parameter int unsigned TIMEOUT      = 1024,
  parameter logic [31:0] HALT_INSTR   = 32'h00000073
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [PC_WIDTH-1:0]  pc,
  input  logic [31:0]          instr,
  input  logic                 retire_valid,
  output logic                 core_reset,
  output logic                 running,
  output logic                 done,
  output logic [1:0]           halt_cause,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [CNT_WIDTH-1:0] retired_count
);

  typedef enum logic [1:0] {IDLE, RESET_HOLD, RUN, DONE} state_t;

  localparam int unsigned          STB_W     = $clog2(HALT_REPEAT + 1);
  localparam logic [STB_W-1:0]     STB_LAST  = STB_W'(HALT_REPEAT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] TO_LAST   = CNT_WIDTH'(TIMEOUT - 1);
  localparam logic [7:0]           HOLD_INIT = 8'(RESET_CYCLES - 1);

  state_t                state, next_state;
  logic [7:0]            hold_cnt;
  logic [STB_W-1:0]      stable_cnt;
  logic [PC_WIDTH-1:0]   pc_q;
  logic                  pc_eq, hit_ecall, hit_loop, hit_timeout, halt;
  logic [1:0]            cause_d;
  logic                  core_reset_d, running_d, done_d;

  // pc_q only holds a valid sample once the first RUN cycle has been counted
  always_comb begin
    pc_eq       = (cycle_count != '0) && (pc == pc_q);
    hit_ecall   = retire_valid && (instr == HALT_INSTR);
    hit_loop    = pc_eq && (stable_cnt == STB_LAST);
    hit_timeout = (cycle_count == TO_LAST);
    halt        = (state == RUN) && (hit_ecall || hit_loop || hit_timeout);
    if (hit_ecall)     cause_d = 2'b01;
    else if (hit_loop) cause_d = 2'b10;
    else               cause_d = 2'b11;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:       if (start) next_state = RESET_HOLD;
      RESET_HOLD: if (hold_cnt == 8'd0) next_state = RUN;
      RUN:        if (halt) next_state = DONE;
      DONE:       if (start) next_state = RESET_HOLD;
      default:    next_state = IDLE;
    endcase
  end

  always_comb begin
    core_reset_d = (next_state != RUN);
    running_d    = (next_state == RUN);
    done_d       = (next_state == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      core_reset <= 1'b1;
      running    <= 1'b0;
      done       <= 1'b0;
    end else begin
      core_reset <= core_reset_d;
      running    <= running_d;
      done       <= done_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_cnt      <= '0;
      stable_cnt    <= '0;
      pc_q          <= '0;
      halt_cause    <= 2'b00;
      cycle_count   <= '0;
      retired_count <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            hold_cnt      <= HOLD_INIT;
            stable_cnt    <= '0;
            pc_q          <= '0;
            halt_cause    <= 2'b00;
            cycle_count   <= '0;
            retired_count <= '0;
          end
        end
        RESET_HOLD: begin
          if (hold_cnt != 8'd0) hold_cnt <= hold_cnt - 8'd1;
        end
        RUN: begin
          if (cycle_count != CNT_MAX) cycle_count <= cycle_count + CNT_ONE;
          if (retire_valid && (retired_count != CNT_MAX))
            retired_count <= retired_count + CNT_ONE;
          pc_q       <= pc;
          stable_cnt <= pc_eq ? stable_cnt + STB_W'(1) : '0;
          if (halt) halt_cause <= cause_d;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_core_run_ctrl.sv
// Bench for core_run_ctrl: directed runs; expected halt results queued at issue, checked by a done-edge monitor.
module tb_core_run_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, retire_valid;
  logic [63:0] pc;
  logic [31:0] instr;
  logic        core_reset, running, done;
  logic [1:0]  halt_cause;
  logic [31:0] cycle_count, retired_count;

  always #5 clk = ~clk;

  core_run_ctrl #(
    .RESET_CYCLES(2), .PC_WIDTH(64), .CNT_WIDTH(32),
    .HALT_REPEAT(4), .TIMEOUT(16), .HALT_INSTR(32'h00000073)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .pc(pc), .instr(instr),
    .retire_valid(retire_valid), .core_reset(core_reset), .running(running),
    .done(done), .halt_cause(halt_cause), .cycle_count(cycle_count),
    .retired_count(retired_count)
  );

  typedef struct {
    string       name;
    logic [1:0]  cause;
    logic [31:0] cyc;
    logic [31:0] ret;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [63:0] pcv = 64'h1000;
  logic        done_q = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_cycle(input logic [63:0] p, input logic rv, input logic [31:0] ins);
    pc           = p;
    retire_valid = rv;
    instr        = ins;
    tick();
    retire_valid = 1'b0;
  endtask

  task automatic expect_done(input string name, input logic [1:0] cause,
                             input logic [31:0] cyc, input logic [31:0] ret);
    exp_t e;
    e.name  = name;
    e.cause = cause;
    e.cyc   = cyc;
    e.ret   = ret;
    exp_q.push_back(e);
  endtask

  task automatic start_run(input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_hold1_core_reset"}, 64'(core_reset), 64'd1);
    check({tag, "_cleared_cycle"}, 64'(cycle_count), 64'd0);
    check({tag, "_cleared_retired"}, 64'(retired_count), 64'd0);
    check({tag, "_cleared_cause_done"}, 64'({halt_cause, done}), 64'd0);
    tick();
    check({tag, "_hold2_rst_run"}, 64'({core_reset, running}), 64'b10);
    tick();
    check({tag, "_run_rst_run"}, 64'({core_reset, running}), 64'b01);
  endtask

  task automatic check_done_state(input string tag);
    check({tag, "_done_rst_run_done"}, 64'({core_reset, running, done}), 64'b101);
  endtask

  task automatic ecall_run(input string tag);
    expect_done(tag, 2'b01, 32'd8, 32'd5);
    start_run(tag);
    for (int i = 1; i <= 3; i++) begin
      run_cycle(pcv, 1'b0, 32'h0);
      pcv = pcv + 64'd4;
      check({tag, "_cycle_inc"}, 64'(cycle_count), 64'(i));
    end
    for (int i = 1; i <= 5; i++) begin
      run_cycle(pcv, 1'b1, (i == 5) ? 32'h00000073 : 32'h00000013);
      pcv = pcv + 64'd4;
    end
    check_done_state(tag);
  endtask

  initial begin
    logic [63:0] seq [7] = '{64'd0, 64'd4, 64'd8, 64'd8, 64'd8, 64'd8, 64'd8};
    exp_t e;

    fork
      forever begin
        @(negedge clk);
        if (done && !done_q) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: cause %0h cycles %0d retired %0d, none expected",
                     halt_cause, cycle_count, retired_count);
          end else begin
            e = exp_q.pop_front();
            check({e.name, "_halt_cause"}, 64'(halt_cause), 64'(e.cause));
            check({e.name, "_cycle_count"}, 64'(cycle_count), 64'(e.cyc));
            check({e.name, "_retired_count"}, 64'(retired_count), 64'(e.ret));
          end
        end
        done_q = done;
      end
    join_none

    reset = 1'b0; start = 1'b0; retire_valid = 1'b0; pc = '0; instr = '0;
    #12;
    check("reset_rst_run_done", 64'({core_reset, running, done}), 64'b100);
    check("reset_cause", 64'(halt_cause), 64'd0);
    check("reset_cycle", 64'(cycle_count), 64'd0);
    check("reset_retired", 64'(retired_count), 64'd0);
    #3;
    reset = 1'b1;
    tick(); tick(); tick();

    ecall_run("first");

    expect_done("loop", 2'b10, 32'd7, 32'd0);
    start_run("loop");
    for (int i = 0; i < 7; i++) begin
      run_cycle(seq[i], 1'b0, 32'h0);
      if (i == 5) check("loop_not_yet_done", 64'(done), 64'd0);
    end
    check_done_state("loop");

    expect_done("timeout", 2'b11, 32'd16, 32'd0);
    start_run("timeout");
    for (int i = 1; i <= 16; i++) begin
      run_cycle(pcv, 1'b0, 32'h0);
      pcv = pcv + 64'd4;
      if (i == 15) check("timeout_c15_running_done", 64'({running, done}), 64'b10);
    end
    check_done_state("timeout");

    expect_done("ecall_at_timeout", 2'b01, 32'd16, 32'd1);
    start_run("ecall_at_timeout");
    for (int i = 1; i <= 16; i++) begin
      run_cycle(pcv, (i == 16), 32'h00000073);
      pcv = pcv + 64'd4;
    end
    check_done_state("ecall_at_timeout");

    expect_done("loop_at_timeout", 2'b10, 32'd16, 32'd0);
    start_run("loop_at_timeout");
    for (int i = 1; i <= 16; i++)
      run_cycle((i <= 12) ? 64'h2000 + 64'(4 * i) : 64'h2030, 1'b0, 32'h0);

    expect_done("ecall_over_loop", 2'b01, 32'd7, 32'd1);
    start_run("ecall_over_loop");
    for (int i = 0; i < 7; i++)
      run_cycle(seq[i], (i == 6), 32'h00000073);

    start_run("abort");
    for (int i = 1; i <= 9; i++) begin
      run_cycle(pcv, 1'b1, 32'h00000013);
      pcv = pcv + 64'd4;
    end
    check("abort_cycle_before", 64'(cycle_count), 64'd9);
    #2;
    reset = 1'b0;
    #1;
    check("abort_rst_run_done", 64'({core_reset, running, done}), 64'b100);
    check("abort_cause", 64'(halt_cause), 64'd0);
    check("abort_cycle", 64'(cycle_count), 64'd0);
    check("abort_retired", 64'(retired_count), 64'd0);
    #3;
    reset = 1'b1;
    tick(); tick();
    check("idle_after_abort", 64'({core_reset, running, done}), 64'b100);

    expect_done("restart", 2'b11, 32'd16, 32'd0);
    start_run("restart");
    for (int i = 1; i <= 16; i++) begin
      start = (i == 2);
      run_cycle(pcv, 1'b0, 32'h0);
      start = 1'b0;
      pcv = pcv + 64'd4;
      if (i == 3) check("start_in_run_ignored", 64'({running, cycle_count}), {31'd0, 1'b1, 32'd3});
    end
    check_done_state("restart");

    ecall_run("rerun");

    tick(); tick();
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
